// File: rtl/seq_counter_pkg.sv
// seq_counter_pkg: shared state/mode encodings for seq_counter_fsm
package seq_counter_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;
  typedef enum logic [1:0] {
    M_WRAP     = 2'd0,
    M_ONESHOT  = 2'd1,
    M_PINGPONG = 2'd2,
    M_RSVD     = 2'd3
  } mode_t;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/seq_bin2gray.sv
// seq_bin2gray: combinational binary-to-Gray converter (bin -> gray, WIDTH bits), built with SEQ_COUNTER_GRAY_OUT_EN
`ifdef SEQ_COUNTER_GRAY_OUT_EN
module seq_bin2gray #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);
  assign gray = bin ^ (bin >> 1);
endmodule
`endif

// File: rtl/seq_counter_fsm.sv
// seq_counter_fsm: start/stop/pause counter FSM (wrap/oneshot/pingpong); ports clk, rst, start, stop, en, dir, mode, load, load_val -> count, state_o, tc, busy, and gray when SEQ_COUNTER_GRAY_OUT_EN is defined
module seq_counter_fsm
  import seq_counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state_o,
  output logic             tc,
  output logic             busy
`ifdef SEQ_COUNTER_GRAY_OUT_EN
  ,output logic [WIDTH-1:0] gray
`endif
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  state_t           state, state_n;
  logic [WIDTH-1:0] count_n, inc, dec, step, clamp;
  logic             tc_n, pp_dir, pp_dir_n, pp_valid, pp_valid_n;
  logic             is_pp, is_one, d, at_min, at_max, entry, reload, stepping;
  logic             wrap_tc, end_hit, pp_hit, step_tc, pp_flag;
  // pp_valid marks pp_dir as meaningful; outside PINGPONG it drops so a
  // mid-RUN switch into PINGPONG picks up the live dir input
  always_comb begin
    is_pp      = mode == M_PINGPONG;
    is_one     = mode == M_ONESHOT;
    d          = (is_pp && pp_valid) ? pp_dir : dir;
    at_min     = count == '0;
    at_max     = count == MAXV;
    inc        = count + WIDTH'(1);
    dec        = count - WIDTH'(1);
    clamp      = (32'(load_val) >= MODULUS) ? MAXV : load_val;
    step       = is_pp  ? (d ? (at_min ? inc : dec) : (at_max ? dec : inc)) :
                 is_one ? (d ? (at_min ? count : dec) : (at_max ? count : inc)) :
                          (d ? (at_min ? MAXV : dec) : (at_max ? '0 : inc));
    wrap_tc    = d ? at_min : at_max;
    end_hit    = d ? (step == '0) : (step == MAXV);
    pp_hit     = (step == '0) || (step == MAXV);
    pp_flag    = (step == '0) ? 1'b0 : (step == MAXV) ? 1'b1 : d;
    step_tc    = is_pp ? pp_hit : is_one ? end_hit : wrap_tc;
    entry      = state != S_RUN && start && !stop;
    reload     = entry && state != S_PAUSE;
    stepping   = state == S_RUN && !stop && en && !load;
    state_n    = rst ? S_IDLE :
                 (state == S_RUN && stop) ? S_PAUSE :
                 (state == S_PAUSE && stop) ? S_IDLE :
                 entry ? S_RUN :
                 (stepping && is_one && end_hit) ? S_DONE : state;
    count_n    = rst ? '0 :
                 load ? clamp :
                 (state == S_PAUSE && stop) ? '0 :
                 reload ? (dir ? MAXV : '0) :
                 stepping ? step : count;
    tc_n       = !rst && stepping && step_tc;
    pp_dir_n   = rst ? 1'b0 : entry ? dir : (stepping && is_pp) ? pp_flag : pp_dir;
    pp_valid_n = !rst && is_pp && (entry || pp_valid || stepping);
  end
  always_ff @(posedge clk) begin
    state    <= state_n;
    count    <= count_n;
    tc       <= tc_n;
    pp_dir   <= pp_dir_n;
    pp_valid <= pp_valid_n;
  end
  assign state_o = state;
  assign busy    = state == S_RUN || state == S_PAUSE;
`ifdef SEQ_COUNTER_GRAY_OUT_EN
  logic [WIDTH-1:0] gray_n;
  seq_bin2gray #(.WIDTH(WIDTH)) u_b2g (.bin(count_n), .gray(gray_n));
  always_ff @(posedge clk) gray <= rst ? '0 : gray_n;
`endif
endmodule

// File: tb/tb_seq_counter_fsm.sv
// tb_seq_counter_fsm: directed self-checking bench for seq_counter_fsm (WIDTH=3, MODULUS=6)
module tb_seq_counter_fsm;
  logic       clk = 0, rst = 1, start = 0, stop = 0, en = 0, dir = 0, load = 0;
  logic [1:0] mode = 0;
  logic [2:0] load_val = 0, count;
  logic [1:0] state_o;
  logic       tc, busy;
  int         checks = 0, errors = 0;
`ifdef SEQ_COUNTER_GRAY_OUT_EN
  logic [2:0] gray;
  logic [2:0] gtab [6] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111};
`endif
  seq_counter_fsm #(.WIDTH(3), .MODULUS(6)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .dir(dir),
    .mode(mode), .load(load), .load_val(load_val), .count(count),
    .state_o(state_o), .tc(tc), .busy(busy)
`ifdef SEQ_COUNTER_GRAY_OUT_EN
    , .gray(gray)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  int pp_exp [11] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
  initial begin
    tick; tick;
    chk("rst_count", count, 0); chk("rst_state", state_o, 0);
    chk("rst_tc", tc, 0); chk("rst_busy", busy, 0);
    rst = 0;
    mode = 0; dir = 0; start = 1; en = 1;
    tick;
    chk("wrap_entry_count", count, 0); chk("wrap_entry_state", state_o, 1);
    chk("wrap_entry_busy", busy, 1);
`ifdef SEQ_COUNTER_GRAY_OUT_EN
    chk("gray_0", gray, 0);
`endif
    start = 0;
    for (int i = 1; i <= 6; i++) begin
      tick;
      chk($sformatf("wrap_count%0d", i), count, i % 6);
      chk($sformatf("wrap_tc%0d", i), tc, i == 6);
`ifdef SEQ_COUNTER_GRAY_OUT_EN
      chk($sformatf("gray_%0d", i), gray, gtab[i % 6]);
`endif
    end
    stop = 1; tick;
    chk("stop_pause_state", state_o, 2); chk("stop_pause_count", count, 0);
    tick;
    chk("stop_idle_state", state_o, 0);
    stop = 0; mode = 1; dir = 1; start = 1;
    tick;
    chk("one_entry_count", count, 5);
    start = 0;
    for (int i = 4; i >= 0; i--) begin
      tick;
      chk($sformatf("one_count%0d", i), count, i);
      chk($sformatf("one_tc%0d", i), tc, i == 0);
      chk($sformatf("one_state%0d", i), state_o, i == 0 ? 3 : 1);
    end
    tick; tick;
    chk("one_hold_count", count, 0); chk("one_hold_state", state_o, 3);
    chk("one_hold_tc", tc, 0); chk("one_done_busy", busy, 0);
    mode = 2; dir = 0; start = 1;
    tick;
    chk("pp_entry_count", count, 0);
    start = 0;
    for (int i = 0; i < 11; i++) begin
      tick;
      chk($sformatf("pp_count%0d", i), count, pp_exp[i]);
      chk($sformatf("pp_tc%0d", i), tc, pp_exp[i] == 5 || pp_exp[i] == 0);
    end
    mode = 0;
    tick; tick;
    chk("pre_load_count", count, 3);
    load = 1; load_val = 7;
    tick;
    chk("load_clamp_count", count, 5); chk("load_state", state_o, 1);
    chk("load_tc", tc, 0);
    load = 0;
    tick;
    chk("post_load_wrap_count", count, 0); chk("post_load_wrap_tc", tc, 1);
    load = 1; load_val = 2;
    tick;
    chk("load_plain_count", count, 2);
    load = 0; start = 1; stop = 1;
    tick;
    chk("both_state", state_o, 2); chk("both_count", count, 2);
    chk("pause_busy", busy, 1);
    start = 0;
    tick;
    chk("pause_stop_state", state_o, 0); chk("pause_stop_count", count, 0);
    stop = 0; start = 1;
    tick;
    start = 0;
    tick; tick;
    chk("pre_rst_count", count, 2);
    rst = 1;
    tick;
    chk("mid_rst_state", state_o, 0); chk("mid_rst_count", count, 0);
    chk("mid_rst_tc", tc, 0);
    rst = 0; dir = 1; start = 1; en = 0;
    tick;
    chk("down_entry_count", count, 5);
    start = 0;
    tick;
    chk("en0_hold_count", count, 5);
    en = 1; dir = 0;
    tick;
    chk("up_wrap_count", count, 0); chk("up_wrap_tc", tc, 1);
    dir = 1;
    tick;
    chk("down_wrap_count", count, 5); chk("down_wrap_tc", tc, 1);
    tick;
    chk("down_step_count", count, 4); chk("down_step_tc", tc, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_counter_fsm.md
SEQ_COUNTER_FSM -- requirements
Module: seq_counter_fsm

Interface
REQ-001 Parameter WIDTH, default 3, count width in bits; legal range 2..16.
REQ-002 Parameter MODULUS, default 8, sequence length; count range is 0..MODULUS-1; legal range 2..2**WIDTH.
REQ-003 clk  input  1  clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  level; requests the RUN state.
REQ-006 stop  input  1  level; requests PAUSE from RUN, or IDLE from PAUSE.
REQ-007 en  input  1  step enable; the count advances only in RUN with en=1.
REQ-008 dir  input  1  0=up, 1=down; sampled on every step in WRAP/ONESHOT modes and on the IDLE/DONE->RUN transition.
REQ-009 mode  input  2  00=WRAP, 01=ONESHOT, 10=PINGPONG, 11=reserved (behaves as WRAP).
REQ-010 load  input  1  synchronous load strobe.
REQ-011 load_val  input  WIDTH  value written on load.
REQ-012 count  output  WIDTH  current count, registered.
REQ-013 state_o  output  2  FSM state encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-014 tc  output  1  terminal-count pulse, registered, one cycle wide.
REQ-015 busy  output  1  high when state is RUN or PAUSE (combinational decode of registered state).

Function
REQ-016 Transitions: IDLE+start->RUN; RUN+stop->PAUSE; PAUSE+start->RUN; PAUSE+stop->IDLE; DONE+start->RUN; in every other case the state holds.
REQ-017 When start and stop are both high in the same cycle, stop takes priority.
REQ-018 IDLE/DONE->RUN: count is loaded with 0 if dir=0, or MODULUS-1 if dir=1; PAUSE->RUN preserves count.
REQ-019 PAUSE->IDLE: count clears to 0 on the same edge.
REQ-020 Step latency is one cycle: count reflects the step on the edge on which RUN and en=1 are sampled.
REQ-021 WRAP up: MODULUS-1 -> 0 with tc=1. WRAP down: 0 -> MODULUS-1 with tc=1.
REQ-022 ONESHOT: on reaching the endpoint (MODULUS-1 counting up, 0 counting down), the block asserts tc=1, enters DONE and holds count.
REQ-023 PINGPONG: uses an internal direction flag, initialised from dir on entry to RUN; the flag inverts on each step that lands on 0 or MODULUS-1, and tc=1 on that step.
REQ-024 load has priority over step and over count reloads in every state; it does not change the FSM state; tc=0 on a load cycle.
REQ-025 A load_val >= MODULUS is clamped to MODULUS-1.
REQ-026 A mode change takes effect on the next step; PINGPONG entered mid-RUN initialises its direction flag from dir.
REQ-027 The count never leaves the range 0..MODULUS-1, including on non-power-of-two MODULUS.

Reset
REQ-028 rst=1 forces state=IDLE, count=0, tc=0, direction flag=0, and gray=0 if present; rst overrides every other input.
REQ-029 rst asserted mid-RUN takes effect on the next edge with no partial step.

Configuration
REQ-030 With SEQ_COUNTER_GRAY_OUT_EN defined, output port gray (WIDTH bits, registered) equals the binary-to-Gray conversion of the next count and updates on the same edge as count.
REQ-031 Without SEQ_COUNTER_GRAY_OUT_EN, the gray port and its logic are absent and all other behaviour is identical.

Structure
REQ-032 Package seq_counter_pkg holds the state enum (IDLE/RUN/PAUSE/DONE), the mode enum (WRAP/ONESHOT/PINGPONG/RSVD) and the state_o encodings.
REQ-033 Sub-module seq_bin2gray (parametrised WIDTH, combinational) is instantiated only under SEQ_COUNTER_GRAY_OUT_EN.

Verification
REQ-034 WIDTH=3, MODULUS=6, WRAP, dir=0, start, en=1 for 7 cycles -> count 0,1,2,3,4,5,0; tc=1 only on the 5->0 edge.
REQ-035 MODULUS=6, ONESHOT, dir=1, start -> count 5,4,3,2,1,0; tc pulses once; state_o=3 (DONE); count holds at 0 while en stays high.
REQ-036 MODULUS=6, PINGPONG, dir=0 -> count 0..5,4,3,2,1,0,1; tc=1 on arrival at 5 and at 0.
REQ-037 In RUN at count=3, load=1, load_val=7, en=1 -> count=5 (clamped), state remains RUN, tc=0.
REQ-038 In RUN, start and stop high together -> PAUSE, count held; next cycle stop -> IDLE with count=0; rst mid-RUN -> IDLE and count=0 on the next edge.
REQ-039 With SEQ_COUNTER_GRAY_OUT_EN defined, WRAP MODULUS=8 -> gray sequence 000,001,011,010,110,111,101,100.
